restore_state: RTL and testbench
================================

Name: restore_state

Overview:
- Resume-side counterpart of the save-state stage; runs when a suspended process is rescheduled onto the core.
- After reset is released, it reads the saved context from RAM.
- It then presents stack pointer, call stack pointer, PC, ALU flags and the three top-of-stack registers to the core, and raises finished.
- Shares the RAM port with the save-state stage; the core muxes the two under its own control.

Parameters:
addrBits, `ADDRESS_BITS (8), RAM address width and pointer width
dataBits, `DATA_BITS (16), RAM word width; must equal 2*addrBits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low; low = idle/restart, high = run restore
address  out  addrBits  RAM address
rwMode  out  1  RAM direction; constant `RAM_READ
dataOut  in  dataBits  RAM read data, valid one cycle after address is presented
finished  out  1  high once all context registers are loaded
stackPointer  out  addrBits  restored SP
callStackPointer  out  addrBits  restored CSP
programCounter  out  9  restored PC
aluFlags  out  4  restored ALU flags
topOfStack1  out  dataBits  restored TOS word 0
topOfStack2  out  dataBits  restored TOS word 1
topOfStack3  out  dataBits  restored TOS word 2
corrupt  out  1  only with RESTORE_CHECK_EN; otherwise tied 0

Behaviour:
- Saved layout in RAM:
  - word 0 = {SP, CSP-2}
  - word 1 = {flags[15:12], 3'b000, PC[8:0]}
  - stack words at SP+0, SP+1, SP+2 hold TOS1..3
- State register advances through LOAD_POINTERS(0), LOAD_PC_ALU(1), LOAD_STACK_1(2), LOAD_STACK_2(3), LOAD_STACK_3(4), DONE(5).
- A 1-bit phase register rCycle toggles every edge while reset is high. Each state lasts two cycles:
  - phase 0: address presented
  - phase 1: dataOut valid; captured into the target register on the edge ending phase 1, and the state advances on that same edge.
- Address per state:
  - LOAD_POINTERS: 0
  - LOAD_PC_ALU: 1
  - LOAD_STACK_n: stackPointer+(n-1), using the SP already captured in LOAD_POINTERS
  - DONE: don't-care
- Address arithmetic is modulo 2^addrBits (0xFE+2 = 0x00).
- Captures:
  - LOAD_POINTERS: stackPointer <= dataOut[15:8]; callStackPointer <= dataOut[7:0]+2, modulo 2^addrBits.
  - LOAD_PC_ALU: aluFlags <= dataOut[15:12]; programCounter <= dataOut[8:0]; bits [11:9] are ignored.
  - LOAD_STACK_1..3: topOfStack1..3 <= dataOut.
- finished = (state == DONE), combinational from the registered state. DONE holds, and outputs stay stable, until reset goes low.
- Latency: finished rises on the 10th rising edge with reset sampled high.
- Reset low (at any time, including mid-restore):
  - next edge: state=LOAD_POINTERS, rCycle=0, all context outputs=0, finished=0, corrupt=0
  - re-raising reset restarts from word 0; no partial state is retained
- rwMode is always `RAM_READ; this block never writes RAM.

Optional Feature:
RESTORE_CHECK_EN
- Defined:
  - corrupt is registered and set on the LOAD_PC_ALU capture edge if dataOut[11:9] != 0.
  - corrupt is also set on the LOAD_POINTERS capture edge if the saved SP > 2^addrBits-3, i.e. the stack window would wrap.
  - corrupt is sticky until reset goes low.
  - The restore still completes normally; the core decides the response.
- Undefined: corrupt is constant 0 and no check logic is generated.

Test Plan:
- Normal restore:
  - Stimulus: RAM[0]=0x4012, RAM[1]=0xA105, RAM[0x40..0x42]=0x1111/0x2222/0x3333; reset low, then high.
  - Required response: address sequence 00,00,01,01,40,40,41,41,42,42; SP=0x40, CSP=0x14, flags=0xA, PC=0x105, TOS=0x1111/0x2222/0x3333; finished on edge 10.
- Stack address wrap:
  - Stimulus: RAM[0]=0xFE00.
  - Required response: stack addresses FE,FF,00.
- CSP wrap:
  - Stimulus: RAM[0]=0x10FF.
  - Required response: CSP=0x01.
- Reset mid-restore:
  - Stimulus: drop reset during LOAD_STACK_2, then raise it.
  - Required response: all outputs 0 one edge after the drop; address restarts at 0; finished after 10 further edges.
- Hold in DONE:
  - Stimulus: leave reset high for 20 edges after finished.
  - Required response: outputs unchanged, finished stays 1.
- RESTORE_CHECK_EN:
  - Stimulus: RAM[1]=0x0E00; separately, RAM[0]=0xFF00.
  - Required response: corrupt=1 in each case and stays set until reset low; with the macro undefined, corrupt=0 for both.

Source files
------------

// File: rtl/restore_state.sv
// restore_state: reloads a suspended process's context from RAM after reset
// is released. It walks six states, each two cycles long (address phase, then
// data phase), and raises finished once SP/CSP/PC/flags and the three
// top-of-stack words are loaded.
// Optional build macro RESTORE_CHECK_EN adds a sticky corrupt flag that
// reports non-zero reserved PC bits or a saved SP whose stack window would wrap.

`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif

module restore_state #(
    parameter int addrBits = `ADDRESS_BITS,
    parameter int dataBits = `DATA_BITS
) (
    input  logic                clk,
    input  logic                reset,
    output logic [addrBits-1:0] address,
    output logic                rwMode,
    input  logic [dataBits-1:0] dataOut,
    output logic                finished,
    output logic [addrBits-1:0] stackPointer,
    output logic [addrBits-1:0] callStackPointer,
    output logic [8:0]          programCounter,
    output logic [3:0]          aluFlags,
    output logic [dataBits-1:0] topOfStack1,
    output logic [dataBits-1:0] topOfStack2,
    output logic [dataBits-1:0] topOfStack3,
    output logic                corrupt
);

    typedef enum logic [2:0] {
        LOAD_POINTERS = 3'd0,
        LOAD_PC_ALU   = 3'd1,
        LOAD_STACK_1  = 3'd2,
        LOAD_STACK_2  = 3'd3,
        LOAD_STACK_3  = 3'd4,
        DONE          = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   rCycle;

    // State register and data-phase toggle; both restart whenever reset is low
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= LOAD_POINTERS;
            rCycle  <= 1'b0;
        end else begin
            r_state <= w_next;
            rCycle  <= ~rCycle;
        end
    end

    // Next state advances at the end of the data phase; address follows state
    always_comb begin
        w_next  = r_state;
        address = '0;
        case (r_state)
            LOAD_POINTERS: begin
                address = '0;
                if (rCycle) w_next = LOAD_PC_ALU;
            end
            LOAD_PC_ALU: begin
                address = addrBits'(1);
                if (rCycle) w_next = LOAD_STACK_1;
            end
            LOAD_STACK_1: begin
                address = stackPointer;
                if (rCycle) w_next = LOAD_STACK_2;
            end
            LOAD_STACK_2: begin
                address = stackPointer + addrBits'(1);
                if (rCycle) w_next = LOAD_STACK_3;
            end
            LOAD_STACK_3: begin
                address = stackPointer + addrBits'(2);
                if (rCycle) w_next = DONE;
            end
            default: begin
                address = '0;
                w_next  = DONE;
            end
        endcase
    end

    assign finished = (r_state == DONE);
    assign rwMode   = `RAM_READ;

    // Capture RAM data into the register targeted by the current state
    always_ff @(posedge clk) begin
        if (!reset) begin
            stackPointer     <= '0;
            callStackPointer <= '0;
            programCounter   <= '0;
            aluFlags         <= '0;
            topOfStack1      <= '0;
            topOfStack2      <= '0;
            topOfStack3      <= '0;
        end else if (rCycle) begin
            case (r_state)
                LOAD_POINTERS: begin
                    stackPointer     <= dataOut[dataBits-1:addrBits];
                    // saved CSP is stored two below the live value
                    callStackPointer <= dataOut[addrBits-1:0] + addrBits'(2);
                end
                LOAD_PC_ALU: begin
                    aluFlags       <= dataOut[dataBits-1 -: 4];
                    programCounter <= dataOut[8:0];
                end
                LOAD_STACK_1: topOfStack1 <= dataOut;
                LOAD_STACK_2: topOfStack2 <= dataOut;
                LOAD_STACK_3: topOfStack3 <= dataOut;
                default: ;
            endcase
        end
    end

`ifdef RESTORE_CHECK_EN
    localparam logic [addrBits-1:0] SP_MAX = {addrBits{1'b1}} - addrBits'(2);
    logic r_corrupt;

    // Sticky integrity flag; the restore itself is never aborted
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_corrupt <= 1'b0;
        end else if (rCycle) begin
            if (r_state == LOAD_POINTERS && dataOut[dataBits-1:addrBits] > SP_MAX)
                r_corrupt <= 1'b1;
            if (r_state == LOAD_PC_ALU && dataOut[11:9] != 3'b000)
                r_corrupt <= 1'b1;
        end
    end

    assign corrupt = r_corrupt;
`else
    // reserved PC word bits are only inspected by the check logic
    logic w_unused_bits;
    assign w_unused_bits = ^dataOut[11:9];
    assign corrupt       = 1'b0;
`endif

endmodule

// File: tb/tb_restore_state.sv
// Self-checking bench for restore_state: RAM model with one-cycle read
// latency, reference model derived from the saved-context layout.

`ifndef RAM_READ
`define RAM_READ 1'b0
`endif

module tb_restore_state;

    logic        clk;
    logic        reset;
    logic [7:0]  address;
    logic        rwMode;
    logic [15:0] dataOut;
    logic        finished;
    logic [7:0]  stackPointer;
    logic [7:0]  callStackPointer;
    logic [8:0]  programCounter;
    logic [3:0]  aluFlags;
    logic [15:0] topOfStack1;
    logic [15:0] topOfStack2;
    logic [15:0] topOfStack3;
    logic        corrupt;

    restore_state #(.addrBits(8), .dataBits(16)) dut (
        .clk(clk), .reset(reset), .address(address), .rwMode(rwMode),
        .dataOut(dataOut), .finished(finished), .stackPointer(stackPointer),
        .callStackPointer(callStackPointer), .programCounter(programCounter),
        .aluFlags(aluFlags), .topOfStack1(topOfStack1), .topOfStack2(topOfStack2),
        .topOfStack3(topOfStack3), .corrupt(corrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ram [256];

    // RAM: data for the presented address appears one cycle later
    always @(posedge clk) dataOut <= ram[address];

    int n_cmp = 0;
    int n_err = 0;

    // reference model results
    logic [7:0]  m_addr [10];
    logic [7:0]  m_sp, m_csp;
    logic [8:0]  m_pc;
    logic [3:0]  m_flags;
    logic [15:0] m_tos [3];
    logic        m_corrupt;

    function automatic void model();
        logic [7:0] sp;
        sp      = ram[0][15:8];
        m_sp    = sp;
        m_csp   = ram[0][7:0] + 8'd2;
        m_flags = ram[1][15:12];
        m_pc    = ram[1][8:0];
        for (int k = 0; k < 3; k++) begin
            logic [7:0] a;
            a = sp + 8'(k);
            m_tos[k] = ram[a];
            m_addr[4 + 2*k] = a;
            m_addr[5 + 2*k] = a;
        end
        m_addr[0] = 8'h00; m_addr[1] = 8'h00;
        m_addr[2] = 8'h01; m_addr[3] = 8'h01;
`ifdef RESTORE_CHECK_EN
        m_corrupt = (ram[1][11:9] != 3'b000) || (sp > 8'd253);
`else
        m_corrupt = 1'b0;
`endif
    endfunction

    task automatic fill_ram_random();
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    endtask

    // Full restore of the given context words with per-cycle checking
    task automatic test_restore_case(input string nm, input logic [15:0] w0, input logic [15:0] w1);
        ram[0] = w0;
        ram[1] = w1;
        model();
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({stackPointer, callStackPointer, programCounter, aluFlags, topOfStack1,
             topOfStack2, topOfStack3, finished, corrupt} !== '0) begin
            n_err++;
            $display("FAIL %s reset_zero: sp=%h csp=%h pc=%h fl=%h tos=%h/%h/%h fin=%b cor=%b, want all 0",
                     nm, stackPointer, callStackPointer, programCounter, aluFlags,
                     topOfStack1, topOfStack2, topOfStack3, finished, corrupt);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (address !== m_addr[i] || finished !== 1'b0 || rwMode !== `RAM_READ) begin
                n_err++;
                $display("FAIL %s cycle%0d: addr=%h fin=%b rw=%b, want addr=%h fin=0 rw=%b",
                         nm, i, address, finished, rwMode, m_addr[i], `RAM_READ);
            end
            @(posedge clk); @(negedge clk);
        end
        n_cmp++;
        if (finished !== 1'b1 || stackPointer !== m_sp || callStackPointer !== m_csp ||
            programCounter !== m_pc || aluFlags !== m_flags || topOfStack1 !== m_tos[0] ||
            topOfStack2 !== m_tos[1] || topOfStack3 !== m_tos[2] || corrupt !== m_corrupt) begin
            n_err++;
            $display("FAIL %s context: fin=%b sp=%h csp=%h pc=%h fl=%h tos=%h/%h/%h cor=%b, want fin=1 sp=%h csp=%h pc=%h fl=%h tos=%h/%h/%h cor=%b",
                     nm, finished, stackPointer, callStackPointer, programCounter, aluFlags,
                     topOfStack1, topOfStack2, topOfStack3, corrupt,
                     m_sp, m_csp, m_pc, m_flags, m_tos[0], m_tos[1], m_tos[2], m_corrupt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (finished !== 1'b0 || address !== 8'h00 || corrupt !== 1'b0 || stackPointer !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: fin=%b addr=%h cor=%b sp=%h, want 0/00/0/00",
                     finished, address, corrupt, stackPointer);
        end
    endtask

    task automatic test_normal();
        fill_ram_random();
        ram[8'h40] = 16'h1111; ram[8'h41] = 16'h2222; ram[8'h42] = 16'h3333;
        test_restore_case("normal", 16'h4012, 16'hA105);
        n_cmp++;
        if (stackPointer !== 8'h40 || callStackPointer !== 8'h14 || aluFlags !== 4'hA ||
            programCounter !== 9'h105 || topOfStack1 !== 16'h1111 ||
            topOfStack2 !== 16'h2222 || topOfStack3 !== 16'h3333) begin
            n_err++;
            $display("FAIL normal_const: sp=%h csp=%h fl=%h pc=%h tos=%h/%h/%h, want 40/14/a/105/1111/2222/3333",
                     stackPointer, callStackPointer, aluFlags, programCounter,
                     topOfStack1, topOfStack2, topOfStack3);
        end
    endtask

    task automatic test_stack_wrap();
        fill_ram_random();
        test_restore_case("stack_wrap", 16'hFE00, 16'h0000);
        n_cmp++;
        if (topOfStack3 !== 16'hFE00) begin
            n_err++;
            $display("FAIL stack_wrap_tos3: got %h, want fe00 (word 0)", topOfStack3);
        end
    endtask

    task automatic test_csp_wrap();
        fill_ram_random();
        test_restore_case("csp_wrap", 16'h10FF, 16'h3042);
        n_cmp++;
        if (callStackPointer !== 8'h01) begin
            n_err++;
            $display("FAIL csp_wrap: got %h, want 01", callStackPointer);
        end
    endtask

    task automatic test_reset_mid();
        fill_ram_random();
        ram[0] = 16'h2233; ram[1] = 16'h5155;
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        repeat (6) begin @(posedge clk); @(negedge clk); end
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({stackPointer, callStackPointer, programCounter, aluFlags, topOfStack1,
             topOfStack2, finished, corrupt} !== '0 || address !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid_zero: sp=%h csp=%h pc=%h fl=%h tos1=%h tos2=%h fin=%b addr=%h, want all 0",
                     stackPointer, callStackPointer, programCounter, aluFlags,
                     topOfStack1, topOfStack2, finished, address);
        end
        test_restore_case("reset_mid_restart", 16'h6077, 16'h3088);
    endtask

    task automatic test_hold();
        fill_ram_random();
        test_restore_case("hold_setup", 16'h8090, 16'hC1FF);
        fill_ram_random();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (finished !== 1'b1 || stackPointer !== m_sp || callStackPointer !== m_csp ||
                programCounter !== m_pc || aluFlags !== m_flags || topOfStack1 !== m_tos[0] ||
                topOfStack2 !== m_tos[1] || topOfStack3 !== m_tos[2] || corrupt !== m_corrupt) begin
                n_err++;
                $display("FAIL hold edge%0d: fin=%b sp=%h csp=%h pc=%h fl=%h tos=%h/%h/%h cor=%b",
                         i, finished, stackPointer, callStackPointer, programCounter, aluFlags,
                         topOfStack1, topOfStack2, topOfStack3, corrupt);
            end
        end
    endtask

    task automatic test_check();
        fill_ram_random();
        test_restore_case("check_pcbits", 16'h2000, 16'h0E00);
        repeat (5) begin @(posedge clk); @(negedge clk); end
        n_cmp++;
        if (corrupt !== m_corrupt) begin
            n_err++;
            $display("FAIL check_sticky_pcbits: got %b, want %b", corrupt, m_corrupt);
        end
        fill_ram_random();
        test_restore_case("check_spwrap", 16'hFF00, 16'h0000);
        repeat (5) begin @(posedge clk); @(negedge clk); end
        n_cmp++;
        if (corrupt !== m_corrupt) begin
            n_err++;
            $display("FAIL check_sticky_spwrap: got %b, want %b", corrupt, m_corrupt);
        end
        fill_ram_random();
        test_restore_case("check_sp_fd_ok", 16'hFD00, 16'h01FF);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            logic [15:0] w0, w1;
            fill_ram_random();
            w0 = 16'($urandom);
            w1 = 16'($urandom);
            if (n % 3 == 0) w1[11:9] = 3'b000;
            if (n % 4 == 1) w0[15:8] = 8'($urandom_range(250, 255));
            test_restore_case("random", w0, w1);
        end
    endtask

    initial begin
        reset   = 1'b0;
        dataOut = '0;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        @(negedge clk);
        test_reset();
        test_normal();
        test_stack_wrap();
        test_csp_wrap();
        test_reset_mid();
        test_hold();
        test_check();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
